// File: rtl/rally_speed_sequencer_pkg.sv
// Shared definitions for the rally speed sequencer slice.
//   - rally_state_e : serve / rally phase of the game
//   - LFSR width, tap mask and a next-state helper for the 8-bit Fibonacci LFSR
//   - default parameter values used by the interface, sub-module and top
package rally_pkg;

    typedef enum logic {
        SERVE = 1'b0,
        RALLY = 1'b1
    } rally_state_e;

    localparam int              LFSR_W    = 8;
    // x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    localparam int              DEF_SERVE_FRAMES = 60;
    localparam int              DEF_SPEEDUP_HITS = 8;
    localparam logic [LFSR_W-1:0] DEF_LFSR_SEED  = 8'hA5;
    localparam int              DEF_CNT_W        = 4;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rally_speed_sequencer_if.sv
// Game-side bus of the rally speed sequencer.
//   master : game/collision logic (drives frame/hit/score and mode selects,
//            observes speed/angle/ball enable/hit count)
//   slave  : rally_speed_sequencer
// Signals:
//   i_frame     frame tick pulse        i_hit      paddle collision level
//   i_score     point scored level      i_manualsp manual speed select
//   i_randomsp  random speed mode       i_manualan manual angle select
//   i_randoman  random angle mode       o_speed    ball speed select
//   o_angle     rebound angle select    o_ball_en  ball visible/moving
//   o_hit_count paddle hits in current rally (CNT_W bits, saturating)
interface rally_speed_sequencer_if
    import rally_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             i_frame;
    logic             i_hit;
    logic             i_score;
    logic             i_manualsp;
    logic             i_randomsp;
    logic             i_manualan;
    logic             i_randoman;
    logic             o_speed;
    logic             o_angle;
    logic             o_ball_en;
    logic [CNT_W-1:0] o_hit_count;

    modport master (
        output i_frame, i_hit, i_score, i_manualsp, i_randomsp, i_manualan, i_randoman,
        input  o_speed, o_angle, o_ball_en, o_hit_count
    );

    modport slave (
        input  i_frame, i_hit, i_score, i_manualsp, i_randomsp, i_manualan, i_randoman,
        output o_speed, o_angle, o_ball_en, o_hit_count
    );
endinterface

// File: rtl/rally_speed_sequencer_lfsr.sv
// rally_lfsr8: free-running 8-bit Fibonacci LFSR used as the pseudo-random
// speed/angle source. Shifts left every clock, new bit0 = b7^b5^b4^b3.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset (loads SEED)
//   o_q      current register contents
// SEED must be non-zero or the register locks up at 0.
module rally_lfsr8
    import rally_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEF_LFSR_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [LFSR_W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) o_q <= SEED;
        else          o_q <= lfsr_next(o_q);
    end

endmodule

// File: rtl/rally_speed_sequencer.sv
// rally_speed_sequencer: sequences each rally of the pong core.
//   - serve delay of SERVE_FRAMES frame ticks after reset or a score
//   - per-hit sampling of LFSR bits for random speed/angle
//   - saturating paddle hit counter per rally
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   bus      rally_speed_sequencer_if.slave (game inputs, motion outputs)
// Optional feature macro RALLY_SPEEDUP_EN: once the rally hit count reaches
// SPEEDUP_HITS, o_speed is forced to 1 until the next score.
module rally_speed_sequencer
    import rally_pkg::*;
#(
    parameter int                SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int                SPEEDUP_HITS = DEF_SPEEDUP_HITS,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = DEF_LFSR_SEED,
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    rally_speed_sequencer_if.slave     bus
);

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);

    // Reject configurations that cannot work (zero serve, zero seed locks LFSR).
    generate
        if (SERVE_FRAMES < 1 || SERVE_FRAMES > 255 || LFSR_SEED == '0 || SPEEDUP_HITS < 1)
        begin : g_bad_cfg
            $error("rally_speed_sequencer: invalid parameter set");
        end
    endgenerate

    rally_state_e      state, state_nxt;
    logic              hit_d, score_d;
    logic              hit_p, score_p;
    logic [7:0]        serve_cnt;
    logic [CNT_W-1:0]  hit_count;
    logic              speed_r, angle_r;
    logic [LFSR_W-1:0] lfsr_q;
    logic              ball_en, speed_force;
    logic              serve_done, hit_rally;

    rally_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_q     (lfsr_q)
    );

    // Rising-edge detect on the level inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_d   <= 1'b0;
            score_d <= 1'b0;
        end else begin
            hit_d   <= bus.i_hit;
            score_d <= bus.i_score;
        end
    end

    assign hit_p      = bus.i_hit & ~hit_d;
    assign score_p    = bus.i_score & ~score_d;
    // A score wins over everything else in the same cycle.
    assign serve_done = (state == SERVE) && bus.i_frame && (serve_cnt == 8'd1) && !score_p;
    assign hit_rally  = (state == RALLY) && hit_p && !score_p;

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= SERVE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (score_p)         state_nxt = SERVE;
        else if (serve_done) state_nxt = RALLY;
    end

    // FSM: outputs
    always_comb begin
        ball_en     = (state == RALLY);
        speed_force = 1'b0;
`ifdef RALLY_SPEEDUP_EN
        speed_force = (state == RALLY) && (int'(hit_count) >= SPEEDUP_HITS);
`else
        speed_force = 1'b0;
`endif
    end

    // Serve countdown; reloaded on score so a coincident frame tick is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          serve_cnt <= SERVE_LOAD;
        else if (score_p || serve_done)        serve_cnt <= SERVE_LOAD;
        else if (state == SERVE && bus.i_frame) serve_cnt <= serve_cnt - 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          hit_count <= '0;
        else if (score_p)                      hit_count <= '0;
        else if (hit_rally && hit_count != '1) hit_count <= hit_count + 1'b1;
    end

    // Manual mode tracks the select every cycle; random mode samples the LFSR
    // contents of the hit cycle and holds it between hits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              speed_r <= 1'b0;
        else if (!bus.i_randomsp)  speed_r <= bus.i_manualsp;
        else if (score_p)          speed_r <= 1'b0;
        else if (hit_rally)        speed_r <= lfsr_q[LFSR_W-1];
    end

    // Random angle is deliberately left untouched by a score.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)              angle_r <= 1'b0;
        else if (!bus.i_randoman)  angle_r <= bus.i_manualan;
        else if (hit_rally)        angle_r <= lfsr_q[0];
    end

    assign bus.o_speed     = speed_r | speed_force;
    assign bus.o_angle     = angle_r;
    assign bus.o_ball_en   = ball_en;
    assign bus.o_hit_count = hit_count;

endmodule

// File: tb/tb_rally_speed_sequencer.sv
// Self-checking bench for rally_speed_sequencer (default build, speed-up off).
// A fixed vector table covers serve/rally sequencing in manual modes; hand
// sequences and randomized stimulus are checked against a frame/hit-level
// reference model of the game rules.
module tb_rally_speed_sequencer;

    localparam int SF  = 3;
    localparam int CW  = 4;
    localparam int MAXH = (1 << CW) - 1;

    logic i_clk = 1'b0;
    logic i_rst_n;
    always #5 i_clk = ~i_clk;

    rally_speed_sequencer_if #(.CNT_W(CW)) bus ();

    rally_speed_sequencer #(
        .SERVE_FRAMES (SF),
        .SPEEDUP_HITS (8),
        .LFSR_SEED    (8'hA5),
        .CNT_W        (CW)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_serving;
    int m_frames_left;
    int m_hits;
    bit m_speed, m_angle;
    int m_lfsr;
    bit m_hit_prev, m_score_prev;

    typedef struct {
        bit f, h, s, msp, man;
        bit e_sp, e_an, e_en;
        int e_cnt;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_serving     = 1'b1;
        m_frames_left = SF;
        m_hits        = 0;
        m_speed       = 1'b0;
        m_angle       = 1'b0;
        m_lfsr        = 'hA5;
        m_hit_prev    = 1'b0;
        m_score_prev  = 1'b0;
    endtask

    // One clock of the game rules, applied to the inputs currently driven.
    task automatic model_step();
        bit hp, sp;
        hp = bus.i_hit && !m_hit_prev;
        sp = bus.i_score && !m_score_prev;
        if (!bus.i_randomsp)          m_speed = bus.i_manualsp;
        else if (sp)                  m_speed = 1'b0;
        else if (hp && !m_serving)    m_speed = m_lfsr[7];
        if (!bus.i_randoman)          m_angle = bus.i_manualan;
        else if (hp && !m_serving && !sp) m_angle = m_lfsr[0];
        if (sp) begin
            m_serving     = 1'b1;
            m_frames_left = SF;
            m_hits        = 0;
        end else if (m_serving) begin
            if (bus.i_frame) begin
                if (m_frames_left == 1) m_serving = 1'b0;
                else                    m_frames_left--;
            end
        end else if (hp && m_hits < MAXH) begin
            m_hits++;
        end
        m_hit_prev   = bus.i_hit;
        m_score_prev = bus.i_score;
        m_lfsr = ((m_lfsr << 1) & 255) | ($countones(m_lfsr & 'hB8) % 2);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".speed"}, int'(bus.o_speed),     int'(m_speed));
        chk({tag, ".angle"}, int'(bus.o_angle),     int'(m_angle));
        chk({tag, ".ball_en"}, int'(bus.o_ball_en), int'(!m_serving));
        chk({tag, ".hit_count"}, int'(bus.o_hit_count), m_hits);
    endtask

    task automatic cyc();
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic set_in(input bit f, input bit h, input bit s);
        bus.i_frame = f;
        bus.i_hit   = h;
        bus.i_score = s;
    endtask

    // Score (if needed) and serve back into a rally, checking every cycle.
    task automatic go_rally(input string tag);
        set_in(0, 0, 1); cyc(); check_model(tag);
        set_in(0, 0, 0); cyc(); check_model(tag);
        for (int i = 0; i < SF; i++) begin
            set_in(1, 0, 0); cyc(); check_model(tag);
        end
        set_in(0, 0, 0); cyc(); check_model(tag);
        chk({tag, ".in_rally"}, int'(bus.o_ball_en), 1);
    endtask

    initial begin
        tbl[0]  = '{1,0,0,1,0, 1,0,0, 0};
        tbl[1]  = '{0,0,0,0,1, 0,1,0, 0};
        tbl[2]  = '{1,0,0,1,1, 1,1,0, 0};
        tbl[3]  = '{1,0,0,0,0, 0,0,1, 0};
        tbl[4]  = '{0,1,0,0,0, 0,0,1, 1};
        tbl[5]  = '{1,1,0,1,0, 1,0,1, 1};
        tbl[6]  = '{0,0,0,1,1, 1,1,1, 1};
        tbl[7]  = '{0,1,0,1,1, 1,1,1, 2};
        tbl[8]  = '{0,0,1,0,0, 0,0,0, 0};
        tbl[9]  = '{0,1,1,0,0, 0,0,0, 0};
        tbl[10] = '{1,0,0,0,0, 0,0,0, 0};
        tbl[11] = '{1,0,0,0,0, 0,0,0, 0};
        tbl[12] = '{0,0,0,0,0, 0,0,0, 0};
        tbl[13] = '{1,0,1,0,0, 0,0,0, 0};
        tbl[14] = '{1,0,0,0,0, 0,0,0, 0};
        tbl[15] = '{1,0,0,0,0, 0,0,0, 0};
        tbl[16] = '{1,0,0,0,0, 0,0,1, 0};

        i_rst_n        = 1'b0;
        set_in(0, 0, 0);
        bus.i_manualsp = 1'b0;
        bus.i_randomsp = 1'b0;
        bus.i_manualan = 1'b0;
        bus.i_randoman = 1'b0;
        model_reset();
        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset.speed",     int'(bus.o_speed), 0);
        chk("reset.angle",     int'(bus.o_angle), 0);
        chk("reset.ball_en",   int'(bus.o_ball_en), 0);
        chk("reset.hit_count", int'(bus.o_hit_count), 0);
        i_rst_n = 1'b1;

        // Vector table: manual modes, serve countdown, hits, score priority
        for (int i = 0; i < 17; i++) begin
            set_in(tbl[i].f, tbl[i].h, tbl[i].s);
            bus.i_manualsp = tbl[i].msp;
            bus.i_manualan = tbl[i].man;
            cyc();
            chk($sformatf("vec%0d.speed", i),   int'(bus.o_speed),     int'(tbl[i].e_sp));
            chk($sformatf("vec%0d.angle", i),   int'(bus.o_angle),     int'(tbl[i].e_an));
            chk($sformatf("vec%0d.ball_en", i), int'(bus.o_ball_en),   int'(tbl[i].e_en));
            chk($sformatf("vec%0d.count", i),   int'(bus.o_hit_count), tbl[i].e_cnt);
        end

        // Random speed/angle sampled on hits at varying offsets, held between hits
        bus.i_randomsp = 1'b1;
        bus.i_randoman = 1'b1;
        for (int i = 0; i < 48; i++) begin
            set_in(0, (i % 5 == 1) || (i % 7 == 3), 0);
            cyc(); check_model("rand_hit");
        end

        // Hit and score rising together: score wins
        set_in(0, 0, 0); cyc(); check_model("simul_pre");
        set_in(0, 1, 0); cyc(); check_model("simul_pre");
        set_in(0, 0, 0); cyc(); check_model("simul_pre");
        set_in(0, 1, 1); cyc(); check_model("simul");
        chk("simul.ball_en",   int'(bus.o_ball_en), 0);
        chk("simul.hit_count", int'(bus.o_hit_count), 0);
        chk("simul.speed",     int'(bus.o_speed), 0);
        set_in(0, 0, 0); cyc(); check_model("simul_post");
        for (int i = 0; i < SF; i++) begin
            set_in(1, 0, 0); cyc(); check_model("reserve");
        end

        // 20 hits: counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1, 0); cyc(); check_model("sat");
            set_in(0, 0, 0); cyc(); check_model("sat");
        end
        chk("sat.hit_count", int'(bus.o_hit_count), MAXH);
        set_in(0, 0, 1); cyc(); check_model("sat_score");
        chk("sat_score.hit_count", int'(bus.o_hit_count), 0);
        set_in(0, 0, 0); cyc();

        // Mode switch mid-rally
        go_rally("mode");
        bus.i_randomsp = 1'b1;
        set_in(0, 1, 0); cyc(); check_model("mode");
        set_in(0, 0, 0); cyc(); check_model("mode");
        bus.i_randomsp = 1'b0; bus.i_manualsp = ~bus.o_speed;
        cyc(); check_model("mode_to_manual");
        bus.i_randomsp = 1'b1; bus.i_manualsp = ~bus.i_manualsp;
        for (int i = 0; i < 3; i++) begin cyc(); check_model("mode_to_random"); end

        // Randomized stimulus
        for (int i = 0; i < 400; i++) begin
            bus.i_frame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) bus.i_hit = ~bus.i_hit;
            if (bus.i_score) bus.i_score = ($urandom_range(0, 1) == 0);
            else             bus.i_score = ($urandom_range(0, 39) == 0);
            bus.i_manualsp = 1'($urandom);
            bus.i_manualan = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.i_randomsp = ~bus.i_randomsp;
            if ($urandom_range(0, 15) == 0) bus.i_randoman = ~bus.i_randoman;
            cyc(); check_model("random");
        end

        // Asynchronous reset mid-rally
        bus.i_randomsp = 1'b0; bus.i_randoman = 1'b0;
        bus.i_manualsp = 1'b1; bus.i_manualan = 1'b1;
        go_rally("arst_pre");
        set_in(0, 1, 0); cyc(); check_model("arst_pre");
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst.speed",     int'(bus.o_speed), 0);
        chk("arst.angle",     int'(bus.o_angle), 0);
        chk("arst.ball_en",   int'(bus.o_ball_en), 0);
        chk("arst.hit_count", int'(bus.o_hit_count), 0);
        @(negedge i_clk);
        set_in(0, 0, 0);
        i_rst_n = 1'b1;
        for (int i = 0; i < SF; i++) begin
            chk("arst.serving", int'(bus.o_ball_en), 0);
            set_in(1, 0, 0); cyc(); check_model("arst_serve");
        end
        chk("arst.rally", int'(bus.o_ball_en), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
